// File: rtl/da_z7_ctrl_if.sv
// Handshake, operand and ROM signals of the distributed-arithmetic Z7 controller.
// slave is the controller side, master is the producer/consumer/ROM side.
interface da_z7_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] d3;
    logic        rom_cs;
    logic [2:0]  rom_addr;
    logic [16:0] rom_data;
    logic        z_valid;
    logic        z_ready;
    logic [31:0] z_out;

    modport slave (
        input  in_valid, d0, d1, d2, d3, rom_data, z_ready,
        output in_ready, rom_cs, rom_addr, z_valid, z_out
    );

    modport master (
        output in_valid, d0, d1, d2, d3, rom_data, z_ready,
        input  in_ready, rom_cs, rom_addr, z_valid, z_out
    );
endinterface

// File: rtl/da_z7_ctrl.sv
// Bit-serial distributed-arithmetic Z7 coefficient: one ROM lookup per bit plane,
// 16 planes, accumulated with the sign plane (b=15) subtracted.
module da_z7_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    da_z7_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [3:0]  bcnt;
    logic [15:0] d0_q;
    logic [15:0] d1_q;
    logic [15:0] d2_q;
    logic [15:0] d3_q;
    logic [31:0] acc;

    logic        in_ready_q;
    logic        rom_cs_q;
    logic [2:0]  rom_addr_q;
    logic        z_valid_q;
    logic [31:0] z_out_q;

    logic [3:0]  bcnt_nxt;
    logic [2:0]  addr_nxt;
    logic [2:0]  addr_first;
    logic [31:0] term_ext;
    logic [31:0] term;
    logic [31:0] term_sh;
    logic [31:0] acc_nxt;
    logic        rom_data_unused;

    assign bus.in_ready = in_ready_q;
    assign bus.rom_cs   = rom_cs_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.z_valid  = z_valid_q;
    assign bus.z_out    = z_out_q;

    assign rom_data_unused = bus.rom_data[16];

    // Offset-binary addressing: a set sign bit folds the address and negates the term.
    function automatic logic [2:0] plane_addr(input logic s, input logic a,
                                              input logic b, input logic c);
        return s ? ~{a, b, c} : {a, b, c};
    endfunction

    always_comb begin
        bcnt_nxt   = bcnt + 4'd1;
        addr_nxt   = plane_addr(d0_q[bcnt_nxt], d1_q[bcnt_nxt], d2_q[bcnt_nxt], d3_q[bcnt_nxt]);
        addr_first = plane_addr(bus.d0[0], bus.d1[0], bus.d2[0], bus.d3[0]);
        term_ext   = {{16{bus.rom_data[15]}}, bus.rom_data[15:0]};
        term       = d0_q[bcnt] ? (32'd0 - term_ext) : term_ext;
        term_sh    = term << bcnt;
        acc_nxt    = (bcnt == 4'd15) ? (acc - term_sh) : (acc + term_sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bcnt       <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            d3_q       <= '0;
            acc        <= '0;
            in_ready_q <= 1'b0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            z_valid_q  <= 1'b0;
            z_out_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rom_cs_q   <= 1'b0;
                    rom_addr_q <= '0;
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        d0_q       <= bus.d0;
                        d1_q       <= bus.d1;
                        d2_q       <= bus.d2;
                        d3_q       <= bus.d3;
                        acc        <= '0;
                        bcnt       <= '0;
                        rom_cs_q   <= 1'b1;
                        rom_addr_q <= addr_first;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (bcnt == 4'd15) begin
                        z_out_q    <= acc_nxt;
                        z_valid_q  <= 1'b1;
                        rom_cs_q   <= 1'b0;
                        rom_addr_q <= '0;
                        bcnt       <= '0;
                        state      <= DONE;
                    end else begin
                        bcnt       <= bcnt_nxt;
                        rom_addr_q <= addr_nxt;
                    end
                end
                DONE: begin
                    if (bus.z_ready) begin
                        z_valid_q  <= 1'b0;
                        in_ready_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    rom_cs_q   <= 1'b0;
                    rom_addr_q <= '0;
                    z_valid_q  <= 1'b0;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
